rs485_frame_tx: RTL and testbench
=================================

RS485_FRAME_TX -- requirements
Module: rs485_frame_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per character (5..9).
REQ-002 SHALL have parameter MAX_BYTES, default 16, largest frame length accepted on nbytes.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (>=2).
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per character (1 or 2).
REQ-006 SHALL have parameter DIR_LEAD, default 15, clks between dir_rx rise and dir_tx rise, and between dir_tx rise and first fetch.
REQ-007 SHALL have parameter DIR_LAG, default 4, clks between dir_tx fall and dir_rx fall.
REQ-008 SHALL have parameter ADDR_W, default 9, ROM address width.
REQ-009 SHALL have port clk, input, 1, single clock for all logic.
REQ-010 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-011 SHALL have port rq, input, 1, frame request level from another clock domain.
REQ-012 SHALL have port nbytes, input, clog2(MAX_BYTES+1), frame length, sampled at frame start.
REQ-013 SHALL have port base_addr, input, ADDR_W, first ROM address, sampled at frame start.
REQ-014 SHALL have port rq_rom, output, 1, ROM read request.
REQ-015 SHALL have port ack, input, 1, ROM read acknowledge; data is valid in the same cycle.
REQ-016 SHALL have port data, input, DATA_BITS, ROM read data.
REQ-017 SHALL have port addr, output, ADDR_W, ROM read address.
REQ-018 SHALL have port tx, output, 1, serial line; idle high.
REQ-019 SHALL have port dir_tx, output, 1, RS485 driver enable.
REQ-020 SHALL have port dir_rx, output, 1, RS485 receiver-disable control.
REQ-021 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-022 SHALL have port done, output, 1, one-clk pulse at frame end.

Function
REQ-023 SHALL pass rq through a two-flop synchronizer; all rq decisions use the second flop (rq_s).
REQ-024 SHALL implement the states IDLE, DIRON, FETCH, SHIFT, DIROFF and HOLD.
REQ-025 IDLE: on rq_s=1, SHALL latch nbytes and base_addr, clear the byte index, and go to DIRON; if the latched nbytes=0, SHALL instead pulse done and go to HOLD with the dir pins untouched.
REQ-026 DIRON: SHALL raise dir_rx in the first cycle, raise dir_tx DIR_LEAD clks later, and enter FETCH DIR_LEAD clks after that.
REQ-027 FETCH: SHALL drive addr = base_addr + index (mod 2^ADDR_W) and hold rq_rom=1, with addr stable, until ack=1.
REQ-028 In the ack cycle, SHALL capture data into the shift register; rq_rom SHALL be 0 from the next cycle; the next state SHALL be SHIFT.
REQ-029 SHIFT: SHALL send start bit (0), DATA_BITS data bits LSB first, a parity bit if PARITY!=0, then STOP_BITS stop bits (1); each bit lasts exactly CLKS_PER_BIT clks.
REQ-030 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-031 After the last stop bit, SHALL increment the index and go to FETCH if index<nbytes, else to DIROFF.
REQ-032 DIROFF: SHALL drop dir_tx in the first cycle, drop dir_rx DIR_LAG clks later, and in that same cycle pulse done and go to HOLD.
REQ-033 HOLD: SHALL stay in HOLD until rq_s=0, then go to IDLE; a frame never repeats without rq returning low.
REQ-034 An rq fall during DIRON, FETCH, SHIFT or DIROFF SHALL be ignored; the frame always completes.
REQ-035 If ack is already high on FETCH entry, SHALL complete the fetch in that cycle (one-cycle fetch).
REQ-036 An ack outside FETCH SHALL be ignored.
REQ-037 A nbytes value above MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-038 tx SHALL be 1 in every state except SHIFT.

Reset
REQ-039 When reset=1 at a clk edge, SHALL force IDLE; tx=1; dir_tx=0; dir_rx=0; rq_rom=0; busy=0; done=0; addr=0; and clear counters, index and synchronizer flops.
REQ-040 Reset mid-frame SHALL take effect at the next edge with no trailing bits; after reset release, a still-high rq SHALL start a new frame once synchronized.

Verification
REQ-041 Defaults with CLKS_PER_BIT=4, nbytes=1, base=0x010, data=0xA5, ack one clk after rq_rom -> addr=0x010; tx shows 0,1,0,1,0,0,1,0,1,1, each bit 4 clks; done pulses once.
REQ-042 nbytes=2, base=0x1FF -> reads addr 0x1FF then 0x000 (wrap); two characters sent back-to-back, separated only by the fetch latency.
REQ-043 PARITY=2, STOP_BITS=2, data=0x03 -> parity bit=1 followed by two stop bits; PARITY=1 with the same data -> parity bit=0.
REQ-044 rq high -> dir_rx rises, dir_tx rises 15 clks later, rq_rom rises 15 clks after that; at frame end dir_tx falls and dir_rx falls 4 clks later, in the same cycle as done.
REQ-045 nbytes=0 -> no rq_rom and no dir activity, a single done pulse; a held rq produces no second frame until rq goes low and high again.
REQ-046 Reset asserted during the 3rd data bit -> next cycle tx=1, dir pins=0, busy=0; rq drop mid-frame -> the frame still completes.

Source files
------------

// File: rtl/rs485_frame_tx.sv
// rs485_frame_tx
// Sends a frame of characters, fetched one at a time from a ROM-like read port,
// as asynchronous serial characters on an RS485 line. Around the frame it sequences
// the transceiver controls: receiver disable first, then driver enable, then data.
// Teardown runs in the reverse order.
//
// Ports
//   clk, reset     : single clock, synchronous active-high reset
//   rq             : frame request level (asynchronous, synchronized internally)
//   nbytes         : frame length in characters, clamped to MAX_BYTES
//   base_addr      : first ROM address; later characters use consecutive addresses
//   rq_rom/ack     : ROM read handshake; data is valid in the ack cycle
//   data/addr      : ROM read data and address
//   tx             : serial output, idle high
//   dir_tx, dir_rx : RS485 driver enable / receiver disable
//   busy, done     : busy outside IDLE; done is a one-clk pulse at frame end
module rs485_frame_tx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned MAX_BYTES    = 16,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned DIR_LEAD     = 15,
    parameter int unsigned DIR_LAG      = 4,
    parameter int unsigned ADDR_W       = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rq,
    input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
    input  logic [ADDR_W-1:0]              base_addr,
    output logic                           rq_rom,
    input  logic                           ack,
    input  logic [DATA_BITS-1:0]           data,
    output logic [ADDR_W-1:0]              addr,
    output logic                           tx,
    output logic                           dir_tx,
    output logic                           dir_rx,
    output logic                           busy,
    output logic                           done
);
    localparam int unsigned NB_W    = $clog2(MAX_BYTES + 1);
    localparam int unsigned PAR_W   = (PARITY != 0) ? 1 : 0;
    localparam int unsigned FRAME_W = 1 + DATA_BITS + PAR_W + STOP_BITS;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned LEAD2   = 2 * DIR_LEAD;
    localparam int unsigned MAX_A   = (LEAD2 > CLKS_PER_BIT) ? LEAD2 : CLKS_PER_BIT;
    localparam int unsigned CNT_MAX = (MAX_A > DIR_LAG) ? MAX_A : DIR_LAG;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, DIRON, FETCH, SHIFT, DIROFF, HOLD} state_t;

    state_t               state, state_n;
    logic                 rq_m, rq_s;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bitn, bitn_n;
    logic [FRAME_W-1:0]   shreg, shreg_n;
    logic [NB_W-1:0]      idx, idx_n, nb_l, nb_n;
    logic [ADDR_W-1:0]    base_l, base_n;
    logic                 tx_n, dir_tx_n, dir_rx_n, rq_rom_n, done_n;
    logic [ADDR_W-1:0]    addr_n;
    logic [FRAME_W-1:0]   frame_c;
    logic [NB_W-1:0]      nb_clamp_c;
    logic [NB_W-1:0]      idx_inc_c;

    // Whole character, LSB first: start, data, optional parity, stop bits
    always_comb begin
        frame_c                = '1;
        frame_c[0]             = 1'b0;
        frame_c[DATA_BITS:1]   = data;
        if (PARITY != 0) begin
            frame_c[DATA_BITS+1] = (PARITY == 2) ? ~(^data) : (^data);
        end
    end

    assign nb_clamp_c = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;
    assign idx_inc_c  = idx + NB_W'(1);

    // Next state and next registered outputs
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitn_n   = bitn;
        shreg_n  = shreg;
        idx_n    = idx;
        nb_n     = nb_l;
        base_n   = base_l;
        tx_n     = 1'b1;
        dir_tx_n = dir_tx;
        dir_rx_n = dir_rx;
        rq_rom_n = rq_rom;
        addr_n   = addr;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (rq_s) begin
                    idx_n  = '0;
                    base_n = base_addr;
                    nb_n   = nb_clamp_c;
                    cnt_n  = '0;
                    if (nb_clamp_c == '0) begin
                        // Empty frame: complete without touching the line controls
                        done_n  = 1'b1;
                        state_n = HOLD;
                    end else begin
                        dir_rx_n = 1'b1;
                        state_n  = DIRON;
                    end
                end
            end
            DIRON: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIR_LEAD - 1)) begin
                    dir_tx_n = 1'b1;
                end
                if (cnt == CNT_W'(LEAD2 - 1)) begin
                    rq_rom_n = 1'b1;
                    addr_n   = base_l + ADDR_W'(idx);
                    state_n  = FETCH;
                end
            end
            FETCH: begin
                if (ack) begin
                    tx_n     = frame_c[0];
                    shreg_n  = frame_c >> 1;
                    bitn_n   = '0;
                    cnt_n    = '0;
                    rq_rom_n = 1'b0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                tx_n  = tx;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (bitn == BIT_W'(FRAME_W - 1)) begin
                        tx_n  = 1'b1;
                        idx_n = idx_inc_c;
                        if (idx_inc_c < nb_l) begin
                            rq_rom_n = 1'b1;
                            addr_n   = base_l + ADDR_W'(idx_inc_c);
                            state_n  = FETCH;
                        end else begin
                            dir_tx_n = 1'b0;
                            state_n  = DIROFF;
                        end
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                        bitn_n  = bitn + BIT_W'(1);
                    end
                end
            end
            DIROFF: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIR_LAG - 1)) begin
                    dir_rx_n = 1'b0;
                    done_n   = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                // A new frame needs rq to go low first
                if (!rq_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rq_m   <= 1'b0;
            rq_s   <= 1'b0;
            cnt    <= '0;
            bitn   <= '0;
            shreg  <= '1;
            idx    <= '0;
            nb_l   <= '0;
            base_l <= '0;
            tx     <= 1'b1;
            dir_tx <= 1'b0;
            dir_rx <= 1'b0;
            rq_rom <= 1'b0;
            addr   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            rq_m   <= rq;
            rq_s   <= rq_m;
            cnt    <= cnt_n;
            bitn   <= bitn_n;
            shreg  <= shreg_n;
            idx    <= idx_n;
            nb_l   <= nb_n;
            base_l <= base_n;
            tx     <= tx_n;
            dir_tx <= dir_tx_n;
            dir_rx <= dir_rx_n;
            rq_rom <= rq_rom_n;
            addr   <= addr_n;
            busy   <= (state_n != IDLE);
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_rs485_frame_tx.sv
// Testbench for rs485_frame_tx: a table of frames on a no-parity instance, plus
// hand sequences for parity/stop variants, empty frames, reset and rq handling.
module tb_rs485_frame_tx;
    localparam int unsigned AW  = 9;
    localparam int unsigned NBW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic           rq0 = 1'b0, rq_p = 1'b0;
    logic [NBW-1:0] nbytes = '0;
    logic [AW-1:0]  base = '0;
    logic [7:0]     mem [0:511];

    logic          rq_rom0, ack0, ack0_r = 1'b0, ack_force = 1'b0;
    logic [AW-1:0] addr0;
    logic [7:0]    data0;
    logic          tx0, dir_tx0, dir_rx0, busy0, done0;

    logic          rq_rom1, ack1 = 1'b0, tx1, dir_tx1, dir_rx1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [7:0]    data1;
    logic          rq_rom2, ack2 = 1'b0, tx2, dir_tx2, dir_rx2, busy2, done2;
    logic [AW-1:0] addr2;
    logic [7:0]    data2;

    assign ack0  = ack0_r | ack_force;
    assign data0 = mem[addr0];
    assign data1 = mem[addr1];
    assign data2 = mem[addr2];

    rs485_frame_tx #(.CLKS_PER_BIT(4)) u0 (
        .clk(clk), .reset(reset), .rq(rq0), .nbytes(nbytes), .base_addr(base),
        .rq_rom(rq_rom0), .ack(ack0), .data(data0), .addr(addr0), .tx(tx0),
        .dir_tx(dir_tx0), .dir_rx(dir_rx0), .busy(busy0), .done(done0));

    rs485_frame_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .rq(rq_p), .nbytes(nbytes), .base_addr(base),
        .rq_rom(rq_rom1), .ack(ack1), .data(data1), .addr(addr1), .tx(tx1),
        .dir_tx(dir_tx1), .dir_rx(dir_rx1), .busy(busy1), .done(done1));

    rs485_frame_tx #(.CLKS_PER_BIT(4), .PARITY(1)) u2 (
        .clk(clk), .reset(reset), .rq(rq_p), .nbytes(nbytes), .base_addr(base),
        .rq_rom(rq_rom2), .ack(ack2), .data(data2), .addr(addr2), .tx(tx2),
        .dir_tx(dir_tx2), .dir_rx(dir_rx2), .busy(busy2), .done(done2));

    // ROM models: ack one clk after rq_rom, a single-cycle pulse
    always @(posedge clk) begin
        ack0_r <= rq_rom0 && !ack0_r;
        ack1   <= rq_rom1 && !ack1;
        ack2   <= rq_rom2 && !ack2;
    end

    // Monitors on u0: fetched addresses, address stability, done pulses, line activity
    logic [AW-1:0] alog[$];
    logic          pend = 1'b0;
    logic [AW-1:0] paddr = '0;
    int            unstable = 0, done_cnt = 0, act_cnt = 0;
    always @(posedge clk) begin
        if (rq_rom0 && ack0) alog.push_back(addr0);
        if (rq_rom0 && pend && addr0 !== paddr) unstable <= unstable + 1;
        pend  <= rq_rom0 && !ack0;
        paddr <= addr0;
        if (done0) done_cnt <= done_cnt + 1;
        if (dir_rx0 || dir_tx0 || rq_rom0) act_cnt <= act_cnt + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for a start bit on u0, then samples 40 clks (10 bits of 4 clks)
    task automatic capture_char(output logic [9:0] bits, output logic steady, output int gap);
        logic [39:0] s;
        gap = 0;
        while (tx0 !== 1'b0 && gap < 400) begin @(negedge clk); gap++; end
        for (int c = 0; c < 40; c++) begin s[c] = tx0; @(negedge clk); end
        steady = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bits[j] = s[4*j+1];
            for (int c = 0; c < 4; c++) if (s[4*j+c] !== bits[j]) steady = 1'b0;
        end
    endtask

    typedef struct {
        logic [NBW-1:0] nb;
        logic [AW-1:0]  base;
        logic [7:0]     d0, d1;
        logic [9:0]     ch0, ch1;   // expected characters, bit i = i-th bit sent
        logic [AW-1:0]  a0, a1;     // expected fetch addresses
        int             nexp;       // expected number of fetches
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0]  bits;
        logic        steady;
        logic [12:0] p1, p2, dt1, dt2;
        logic [AW-1:0] a_nxt;
        int gap, w, nchk, dc0, ac0;

        vecs[0] = '{5'd1,  9'h010, 8'hA5, 8'h00, 10'h34A, 10'h000, 9'h010, 9'h000, 1};
        vecs[1] = '{5'd2,  9'h1FF, 8'h3C, 8'h81, 10'h278, 10'h302, 9'h1FF, 9'h000, 2};
        vecs[2] = '{5'd31, 9'h100, 8'h00, 8'hFF, 10'h200, 10'h3FE, 9'h100, 9'h101, 16};
        vecs[3] = '{5'd3,  9'h020, 8'h5A, 8'h01, 10'h2B4, 10'h202, 9'h020, 9'h021, 3};

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        p1 = '0; p2 = '0; dt1 = '0; dt2 = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {tx0, dir_tx0, dir_rx0, rq_rom0, busy0, done0}, 6'b100000);
        check("reset_addr", addr0, 9'h000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ack while idle must not start anything
        ack_force = 1'b1; @(negedge clk); ack_force = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_idle_ignored", {busy0, tx0, rq_rom0}, 3'b010);

        for (int v = 0; v < 4; v++) begin
            a_nxt = vecs[v].base + 9'd1;
            mem[vecs[v].base] = vecs[v].d0;
            mem[a_nxt]        = vecs[v].d1;
            alog.delete();
            nbytes = vecs[v].nb;
            base   = vecs[v].base;
            rq0    = 1'b1;

            w = 0; while (!dir_rx0 && w < 20) begin @(negedge clk); w++; end
            check($sformatf("v%0d_dir_rx_rise", v), dir_rx0, 1'b1);
            check($sformatf("v%0d_dir_tx_before_lead", v), dir_tx0, 1'b0);
            w = 0; while (!dir_tx0 && w < 40) begin @(negedge clk); w++; end
            check($sformatf("v%0d_lead_rx_to_tx", v), w, 15);
            w = 0; while (!rq_rom0 && w < 40) begin @(negedge clk); w++; end
            check($sformatf("v%0d_lead_tx_to_rom", v), w, 15);

            nchk = (vecs[v].nexp < 2) ? vecs[v].nexp : 2;
            for (int k = 0; k < nchk; k++) begin
                capture_char(bits, steady, gap);
                check($sformatf("v%0d_char%0d", v, k), bits, (k == 0) ? vecs[v].ch0 : vecs[v].ch1);
                check($sformatf("v%0d_char%0d_bitlen", v, k), steady, 1'b1);
                if (k == 1) check($sformatf("v%0d_fetch_gap", v), gap, 2);
            end

            if (vecs[v].nexp <= 2) begin
                check($sformatf("v%0d_dir_tx_fall", v), {dir_tx0, dir_rx0}, 2'b01);
                w = 0; while (!done0 && w < 20) begin @(negedge clk); w++; end
                check($sformatf("v%0d_lag", v), w, 4);
                check($sformatf("v%0d_dir_rx_with_done", v), dir_rx0, 1'b0);
            end else begin
                w = 0; while (!done0 && w < 2000) begin @(negedge clk); w++; end
                check($sformatf("v%0d_done_seen", v), done0, 1'b1);
            end
            @(negedge clk);
            check($sformatf("v%0d_done_one_clk", v), done0, 1'b0);
            check($sformatf("v%0d_hold_busy", v), busy0, 1'b1);
            check($sformatf("v%0d_nfetch", v), alog.size(), vecs[v].nexp);
            check($sformatf("v%0d_addr0", v), alog[0], vecs[v].a0);
            if (vecs[v].nexp > 1) check($sformatf("v%0d_addr1", v), alog[1], vecs[v].a1);
            rq0 = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_back_idle", v), {busy0, tx0}, 2'b01);
        end
        check("addr_stable", unstable, 0);

        // Empty frame: single done, no line activity, no repeat while rq held
        nbytes = 5'd0;
        dc0 = done_cnt; ac0 = act_cnt;
        rq0 = 1'b1;
        repeat (40) @(negedge clk);
        check("nb0_one_done", done_cnt - dc0, 1);
        check("nb0_no_activity", act_cnt - ac0, 0);
        check("nb0_hold", busy0, 1'b1);
        rq0 = 1'b0;
        repeat (4) @(negedge clk);
        check("nb0_idle", busy0, 1'b0);
        rq0 = 1'b1;
        repeat (8) @(negedge clk);
        check("nb0_second_frame", done_cnt - dc0, 2);
        rq0 = 1'b0;
        repeat (4) @(negedge clk);

        // Parity variants: odd parity with two stops, even parity with one stop
        mem[9'h040] = 8'h03;
        nbytes = 5'd1; base = 9'h040;
        rq_p = 1'b1;
        w = 0; while (tx1 !== 1'b0 && w < 200) begin @(negedge clk); w++; end
        check("par_start_aligned", {tx1, tx2}, 2'b00);
        for (int c = 0; c < 52; c++) begin
            if (c % 4 == 1) begin
                p1[c/4] = tx1; p2[c/4] = tx2; dt1[c/4] = dir_tx1; dt2[c/4] = dir_tx2;
            end
            @(negedge clk);
        end
        check("odd_2stop_frame", p1[11:0], 12'hE06);
        check("even_1stop_frame", p2[10:0], 11'h406);
        check("odd_2stop_driver", {dt1[11], dt1[12]}, 2'b10);
        check("even_1stop_driver", dt2[11], 1'b0);
        w = 0; while (!done1 && w < 50) begin @(negedge clk); w++; end
        check("odd_done", done1, 1'b1);
        rq_p = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the third data bit, then restart with rq still high
        nbytes = 5'd1; base = 9'h010;
        rq0 = 1'b1;
        w = 0; while (tx0 !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {tx0, dir_tx0, dir_rx0, busy0, rq_rom0, done0}, 6'b100000);
        check("midreset_addr", addr0, 9'h000);
        reset = 1'b0;
        w = 0; while (!dir_rx0 && w < 20) begin @(negedge clk); w++; end
        check("restart_after_reset", dir_rx0, 1'b1);
        rq0 = 1'b0;
        capture_char(bits, steady, gap);
        check("rq_drop_char", bits, 10'h34A);
        w = 0; while (!done0 && w < 50) begin @(negedge clk); w++; end
        check("rq_drop_done", done0, 1'b1);
        repeat (4) @(negedge clk);
        check("rq_drop_idle", busy0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
